// File: rtl/bht_ctrl_pkg.sv
// Shared definitions for the branch history table: counter encodings,
// controller states and the saturating counter helpers.
package bht_ctrl_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == ST) ? ST : cnt + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Entry storage for the branch history table: one asynchronous read port and
// one write port that can update either the whole entry or only its counter.
module bht_table #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [1:0]         rd_cnt,
  input  logic               wr_en,
  input  logic               wr_cnt_only,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_valid,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [1:0]         wr_cnt
);

  localparam int DEPTH = 1 << INDEX_W;

  // No reset here: the controller sweeps the valid bits clear after reset.
  logic             entry_valid [DEPTH];
  logic [TAG_W-1:0] entry_tag   [DEPTH];
  logic [1:0]       entry_cnt   [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_cnt[wr_idx] <= wr_cnt;
      if (!wr_cnt_only) begin
        entry_valid[wr_idx] <= wr_valid;
        entry_tag[wr_idx]   <= wr_tag;
      end
    end
  end

  assign rd_valid = entry_valid[rd_idx];
  assign rd_tag   = entry_tag[rd_idx];
  assign rd_cnt   = entry_cnt[rd_idx];

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: IF-stage lookup, EX-stage counter update or
// allocation, post-reset invalidation sweep, and branch/mispredict statistics.
//
//   state | meaning
//   INIT  | clearing one entry per cycle; lookups miss, updates ignored
//   READY | serving lookups and applying EX-stage resolutions
module bht_ctrl
  import bht_ctrl_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        bht_hit,
  output logic [1:0]  bht_pred_br,
  output logic        pred_taken,
  input  logic        br_valid_ex,
  input  logic [31:0] pc_ex,
  input  logic        br_taken_ex,
  input  logic        bht_hit_ex,
  input  logic [1:0]  bht_pred_br_ex,
  input  logic        bubbleE,
  output logic        mispredict_ex,
  output logic        init_done,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  state_t             state, state_nx;
  logic [INDEX_W-1:0] sweep_idx;
  logic               update;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [1:0]         rd_cnt;

  logic               wr_en;
  logic               wr_cnt_only;
  logic [INDEX_W-1:0] wr_idx;
  logic               wr_valid;
  logic [TAG_W-1:0]   wr_tag;
  logic [1:0]         wr_cnt;

  logic [INDEX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0]   tag_if, tag_ex;
  logic               unused_pc;

  assign idx_if = pc_if[INDEX_W+1:2];
  assign tag_if = pc_if[INDEX_W+2 +: TAG_W];
  assign idx_ex = pc_ex[INDEX_W+1:2];
  assign tag_ex = pc_ex[INDEX_W+2 +: TAG_W];
  assign unused_pc = ^{pc_if[31:INDEX_W+2+TAG_W], pc_if[1:0],
                       pc_ex[31:INDEX_W+2+TAG_W], pc_ex[1:0]};

  bht_table #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_table (
    .clk         (clk),
    .rd_idx      (idx_if),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_cnt      (rd_cnt),
    .wr_en       (wr_en),
    .wr_cnt_only (wr_cnt_only),
    .wr_idx      (wr_idx),
    .wr_valid    (wr_valid),
    .wr_tag      (wr_tag),
    .wr_cnt      (wr_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (&sweep_idx) state_nx = READY;
      READY:   state_nx = READY;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)             sweep_idx <= '0;
    else if (state == INIT) sweep_idx <= sweep_idx + 1'b1;
  end

  assign update        = (state == READY) & br_valid_ex & ~bubbleE;
  assign mispredict_ex = br_valid_ex & ~bubbleE &
                         ((bht_hit_ex & bht_pred_br_ex[1]) != br_taken_ex);

  always_comb begin
    wr_en       = 1'b0;
    wr_cnt_only = 1'b0;
    wr_idx      = sweep_idx;
    wr_valid    = 1'b0;
    wr_tag      = '0;
    wr_cnt      = SNT;
    init_done   = (state == READY);
    case (state)
      INIT: wr_en = rst_n;
      READY: begin
        wr_idx   = idx_ex;
        wr_valid = 1'b1;
        wr_tag   = tag_ex;
        if (bht_hit_ex) begin
          // The counter carried down the pipe is the base, not the table copy.
          wr_en       = rst_n & update;
          wr_cnt_only = 1'b1;
          wr_cnt      = br_taken_ex ? sat_inc(bht_pred_br_ex) : sat_dec(bht_pred_br_ex);
        end else begin
          wr_en  = rst_n & update & br_taken_ex;
          wr_cnt = WT;
        end
      end
      default: wr_en = 1'b0;
    endcase
  end

  assign bht_hit     = (state == READY) & rd_valid & (rd_tag == tag_if);
  assign bht_pred_br = bht_hit ? rd_cnt : SNT;
  assign pred_taken  = bht_hit & bht_pred_br[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (update) begin
      br_count <= br_count + 32'd1;
      if (mispredict_ex) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule
